// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the CPU front end: the
//                fetch/execute sequencer state encoding, the full-word byte
//                enable, and the reset values that the sequencer and the PC
//                must agree on.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Sequencer states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC1  = 2'd1,
        ST_EXEC2  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    // Instruction fetches are always full 32-bit words.
    localparam logic [3:0]  c_BE_FULL     = 4'hF;

    // Instruction register value after reset (encodes a NOP).
    localparam logic [31:0] c_RESET_INSTR = 32'h0000_0000;

    // PC value after reset; kept here so the PC and the sequencer agree.
    localparam logic [31:0] c_RESET_PC    = 32'hBFC0_0000;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fetch_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_watchdog
//  Description : Counts consecutive waitrequest cycles of an outstanding
//                instruction read and flags a trip when the count has
//                reached WDOG_LIMIT and the bus is still waiting.
//  Ports       : clk        - system clock
//                rst_n      - asynchronous active-low reset
//                i_count_en - read issued and waitrequest high this cycle
//                i_clear    - read completed or sequencer not in FETCH
//                o_trip     - combinational trip indication
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_watchdog #(
    parameter int WDOG_LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_count_en,
    input  logic i_clear,
    output logic o_trip
);

    localparam int c_CW = $clog2(WDOG_LIMIT + 1);
    localparam logic [c_CW-1:0] c_LIMIT = c_CW'(WDOG_LIMIT);

    logic [c_CW-1:0] r_count;
    logic            w_at_limit;

    assign w_at_limit = (r_count == c_LIMIT);

    // Trip only while the bus is still stalling once the limit is reached.
    assign o_trip = i_count_en & w_at_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en && !w_at_limit) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : fetch_watchdog
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction fetch and cycle sequencer. Issues the
//                instruction read at the current PC, absorbs waitrequest
//                stalls, captures the returned word into the instruction
//                register and produces one-hot fetch/exec1/exec2 strobes.
//                Halts permanently (until reset) when the PC reports 0.
//  Config      : FETCH_WATCHDOG_EN - when defined, a waitrequest watchdog
//                halts the sequencer and raises bus_error after WDOG_LIMIT
//                consecutive stalled fetch cycles.
//  Ports       : clk, reset (async, active low)
//                pc_address, pc_halt     - from the PC
//                mem_stall               - datapath data-access stall
//                waitrequest, readdata   - bus responses
//                address, read, byteenable - bus request
//                instr                   - instruction register
//                fetch, exec1, exec2     - one-hot cycle strobes
//                active, bus_error       - run / watchdog status
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int          WDOG_LIMIT  = 255,
    parameter logic [31:0] RESET_INSTR = cpu_pkg::c_RESET_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_address,
    input  logic        pc_halt,
    input  logic        mem_stall,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic [31:0] address,
    output logic        read,
    output logic [3:0]  byteenable,
    output logic [31:0] instr,
    output logic        fetch,
    output logic        exec1,
    output logic        exec2,
    output logic        active,
    output logic        bus_error
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_instr;
    logic        r_bus_error;
    logic        w_read;
    logic        w_fetch;
    logic        w_exec1;
    logic        w_exec2;
    logic        w_wdog_trip;

    // ------------------------------------------------------------------
    // Next-state and strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next  = r_state;
        w_read  = 1'b0;
        w_fetch = 1'b0;
        w_exec1 = 1'b0;
        w_exec2 = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (pc_halt) begin
                    // Halt has priority over any bus activity.
                    w_next = ST_HALTED;
                end else if (reset) begin
                    // The reset term keeps read low while reset is held,
                    // even though the state register already reads FETCH.
                    w_read = 1'b1;
                    if (!waitrequest) begin
                        w_fetch = 1'b1;
                        w_next  = ST_EXEC1;
                    end else if (w_wdog_trip) begin
                        w_next = ST_HALTED;
                    end
                end
            end
            ST_EXEC1: begin
                w_exec1 = 1'b1;
                if (!mem_stall) begin
                    w_next = ST_EXEC2;
                end
            end
            ST_EXEC2: begin
                w_exec2 = 1'b1;
                w_next  = ST_FETCH;
            end
            default: begin
                w_next = ST_HALTED;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, instruction register and sticky error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_FETCH;
            r_instr     <= RESET_INSTR;
            r_bus_error <= 1'b0;
        end else begin
            r_state <= w_next;
            // w_fetch is exactly read & !waitrequest, the only moment
            // readdata is valid.
            if (w_fetch) begin
                r_instr <= readdata;
            end
            if (w_wdog_trip) begin
                r_bus_error <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional waitrequest watchdog
    // ------------------------------------------------------------------
`ifdef FETCH_WATCHDOG_EN
    logic w_wdog_count_en;
    logic w_wdog_clear;

    assign w_wdog_count_en = w_read & waitrequest;
    assign w_wdog_clear    = (r_state != ST_FETCH) | w_fetch;

    fetch_watchdog #(
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_fetch_watchdog (
        .clk        (clk),
        .rst_n      (reset),
        .i_count_en (w_wdog_count_en),
        .i_clear    (w_wdog_clear),
        .o_trip     (w_wdog_trip)
    );
`else
    // Without the watchdog the limit has no effect; FETCH waits forever.
    logic w_unused_wdog_limit;
    assign w_unused_wdog_limit = (WDOG_LIMIT != 0);
    assign w_wdog_trip         = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign address    = pc_address;
    assign read       = w_read;
    assign byteenable = w_read ? c_BE_FULL : 4'h0;
    assign instr      = r_instr;
    assign fetch      = w_fetch;
    assign exec1      = w_exec1;
    assign exec2      = w_exec2;
    assign active     = (r_state != ST_HALTED);
    assign bus_error  = r_bus_error;

endmodule : fetch_sequencer
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Directed self-checking bench for fetch_sequencer.
//  Config      : FETCH_WATCHDOG_EN selects the watchdog expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] pc_address;
    logic        pc_halt;
    logic        mem_stall;
    logic        waitrequest;
    logic [31:0] readdata;
    logic [31:0] address;
    logic        read;
    logic [3:0]  byteenable;
    logic [31:0] instr;
    logic        fetch;
    logic        exec1;
    logic        exec2;
    logic        active;
    logic        bus_error;

    int errors = 0;
    int checks = 0;

    fetch_sequencer #(
        .WDOG_LIMIT  (4),
        .RESET_INSTR (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_address  (pc_address),
        .pc_halt     (pc_halt),
        .mem_stall   (mem_stall),
        .waitrequest (waitrequest),
        .readdata    (readdata),
        .address     (address),
        .read        (read),
        .byteenable  (byteenable),
        .instr       (instr),
        .fetch       (fetch),
        .exec1       (exec1),
        .exec2       (exec2),
        .active      (active),
        .bus_error   (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Strobe vector {read, fetch, exec1, exec2, active}
    function automatic logic [31:0] strb();
        return {27'd0, read, fetch, exec1, exec2, active};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        logic [31:0] held;

        reset       = 1'b0;
        pc_address  = 32'hBFC0_0000;
        pc_halt     = 1'b0;
        mem_stall   = 1'b0;
        waitrequest = 1'b1;
        readdata    = 32'hDEAD_BEEF;
        #2;
        chk("reset_strobes", strb(), 32'b00001);
        chk("reset_instr", instr, 32'h0000_0000);
        chk("reset_bus_error", {31'd0, bus_error}, 32'd0);
        waitrequest = 1'b0;
        tick();
        #1;
        chk("reset_read_low_nowait", strb(), 32'b00001);
        tick();

        // Zero-wait fetch
        reset    = 1'b1;
        readdata = 32'h2402_0005;
        #1;
        chk("zw_fetch_strobes", strb(), 32'b11001);
        chk("zw_address", address, 32'hBFC0_0000);
        chk("zw_byteenable", {28'd0, byteenable}, 32'hF);
        tick();
        readdata = 32'h1111_1111;
        chk("zw_instr", instr, 32'h2402_0005);
        chk("zw_exec1", strb(), 32'b00101);
        tick();
        chk("zw_exec2", strb(), 32'b00011);
        chk("zw_instr_hold", instr, 32'h2402_0005);
        tick();
        chk("zw_refetch_c4", {31'd0, read}, 32'd1);

        // Three wait states
        waitrequest = 1'b1;
        pc_address  = 32'h0000_1000;
        readdata    = 32'hAAAA_AAAA;
        #1;
        chk("ws_c1", strb(), 32'b10001);
        tick();
        chk("ws_c2", strb(), 32'b10001);
        chk("ws_instr_hold", instr, 32'h2402_0005);
        tick();
        chk("ws_c3_addr", address, 32'h0000_1000);
        tick();
        waitrequest = 1'b0;
        readdata    = 32'h3C01_0040;
        #1;
        chk("ws_c4_complete", strb(), 32'b11001);
        tick();
        chk("ws_instr", instr, 32'h3C01_0040);

        // mem_stall on EXEC1 entry for two cycles
        mem_stall = 1'b1;
        #1;
        chk("ms_c1", strb(), 32'b00101);
        tick();
        chk("ms_c2", strb(), 32'b00101);
        tick();
        mem_stall = 1'b0;
        #1;
        chk("ms_c3", strb(), 32'b00101);
        tick();
        mem_stall = 1'b1;  // ignored in EXEC2
        #1;
        chk("ms_exec2", strb(), 32'b00011);
        tick();
        mem_stall = 1'b0;
        chk("ms_back_fetch", {31'd0, read}, 32'd1);

        // Asynchronous reset mid-stall
        waitrequest = 1'b1;
        #1;
        chk("ar_pre_read", {31'd0, read}, 32'd1);
        reset = 1'b0;
        #1;
        chk("ar_strobes", strb(), 32'b00001);
        chk("ar_instr", instr, 32'h0000_0000);
        reset       = 1'b1;
        waitrequest = 1'b0;
        readdata    = 32'h0000_0001;
        pc_address  = 32'hBFC0_0000;
        #1;
        chk("ar_fresh_fetch", strb(), 32'b11001);
        tick();
        chk("ar_fresh_instr", instr, 32'h0000_0001);
        tick();
        tick();
        chk("ar_refetch", {31'd0, read}, 32'd1);

        // Extended waitrequest
        waitrequest = 1'b1;
`ifdef FETCH_WATCHDOG_EN
        for (int i = 0; i < 4; i++) tick();
        chk("wd_still_reading", strb(), 32'b10001);
        tick();
        chk("wd_halted", strb(), 32'b00000);
        chk("wd_bus_error", {31'd0, bus_error}, 32'd1);
        tick();
        chk("wd_stays_halted", strb(), 32'b00000);
`else
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (read !== 1'b1 || fetch !== 1'b0) bad++;
        end
        chk("nowd_read_held", bad, 0);
        chk("nowd_bus_error", {31'd0, bus_error}, 32'd0);
`endif

        // Restart from reset, then halt with simultaneous waitrequest
        reset = 1'b0;
        #1;
        reset       = 1'b1;
        waitrequest = 1'b0;
        readdata    = 32'h0BAD_F00D;
        #1;
        chk("pr_bus_error_clear", {31'd0, bus_error}, 32'd0);
        tick();
        chk("pr_instr", instr, 32'h0BAD_F00D);
        tick();
        tick();
        pc_halt     = 1'b1;
        waitrequest = 1'b1;
        pc_address  = 32'h0000_0000;
        #1;
        chk("halt_no_read", strb(), 32'b00001);
        tick();
        chk("halt_state", strb(), 32'b00000);
        held = instr;
        chk("halt_instr_held", held, 32'h0BAD_F00D);

        bad = 0;
        for (int i = 0; i < 50; i++) begin
            pc_halt     = 1'($urandom_range(0, 1));
            waitrequest = 1'($urandom_range(0, 1));
            mem_stall   = 1'($urandom_range(0, 1));
            readdata    = $urandom;
            pc_address  = $urandom;
            #1;
            if (strb() !== 32'd0) bad++;
            tick();
            if (strb() !== 32'd0 || instr !== held) bad++;
        end
        chk("halt_sticky_50", bad, 0);

        // Only reset exits HALTED
        pc_halt     = 1'b0;
        waitrequest = 1'b0;
        mem_stall   = 1'b0;
        readdata    = 32'h2402_0005;
        reset       = 1'b0;
        #1;
        chk("halt_reset_instr", instr, 32'h0000_0000);
        reset = 1'b1;
        #1;
        chk("halt_exit_fetch", strb(), 32'b11001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_sequencer
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch and cycle-sequencing stage, directly upstream of the program counter.
- Issues the instruction read on the Avalon-style memory bus at the PC's current address, absorbs waitrequest stalls, and latches the returned word into the instruction register.
- Generates the one-hot fetch/exec1/exec2 strobes that advance the PC and the rest of the datapath.
- Enters a sticky halted state once the PC reports address 0.

Parameters:
- WDOG_LIMIT, 255: max consecutive waitrequest cycles tolerated in FETCH (used only with FETCH_WATCHDOG_EN).
- RESET_INSTR, 32'h0000_0000: instruction register value after reset (a NOP).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- pc_address  in  32  current PC value.
- pc_halt  in  1  PC reports address == 0.
- mem_stall  in  1  datapath data-access stall; holds EXEC1.
- waitrequest  in  1  bus wait.
- readdata  in  32  bus read data.
- address  out  32  bus address.
- read  out  1  bus read strobe.
- byteenable  out  4  bus byte enables.
- instr  out  32  instruction register.
- fetch  out  1  fetch strobe to PC/datapath.
- exec1  out  1  exec1 strobe.
- exec2  out  1  exec2 strobe.
- active  out  1  CPU running (0 once halted).
- bus_error  out  1  watchdog trip flag (tied 0 without FETCH_WATCHDOG_EN).

Behaviour:
- States: FETCH, EXEC1, EXEC2, HALTED, encoded as a 2-bit enum.
- Reset (reset=0, async):
  - state=FETCH, instr=RESET_INSTR.
  - fetch/exec1/exec2=0, active=1, bus_error=0.
  - read=0 while reset is asserted; outputs settle to FETCH decode after release.
- FETCH, pc_halt=1 (checked first):
  - read=0, no strobes.
  - Next state HALTED; instr is unchanged.
- FETCH, pc_halt=0:
  - address=pc_address, read=1, byteenable=4'hF (combinational from state).
  - While waitrequest=1: stay in FETCH, fetch=0, address held from pc_address.
  - First cycle with waitrequest=0: fetch=1 for exactly that cycle; instr<=readdata on the same edge; next state EXEC1.
  - Fetch-to-first-EXEC1 latency is 1 cycle with zero wait states.
- EXEC1:
  - read=0, exec1=1.
  - If mem_stall=1, stay in EXEC1 with exec1 held high.
  - Else next state EXEC2.
- EXEC2: exec2=1 for one cycle, then next state FETCH.
- HALTED:
  - All strobes 0, read=0, active=0.
  - Sticky; only reset exits.
- Invariants:
  - At most one of fetch/exec1/exec2 is high in any cycle.
  - read=1 only in FETCH.
  - Minimum instruction period is 3 cycles.
- readdata is sampled only when read=1 and waitrequest=0. Data presented at any other time is ignored.
- Simultaneous pc_halt and waitrequest in FETCH: halt wins and no read is issued.
- Reset asserted mid-stall or mid-EXEC: immediate return to reset values, regardless of bus state.
- mem_stall outside EXEC1 is ignored.

Optional Feature:
- Macro: FETCH_WATCHDOG_EN.
- Defined:
  - A counter of width $clog2(WDOG_LIMIT+1) increments each FETCH cycle with read=1 and waitrequest=1.
  - The counter clears on any completed read and on leaving FETCH.
  - When the counter reaches WDOG_LIMIT and waitrequest is still 1: bus_error<=1 (sticky), next state HALTED, read drops the following cycle.
- Undefined: no counter is present, bus_error is constant 0, and FETCH waits indefinitely.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum (FETCH/EXEC1/EXEC2/HALTED);
  - the 4'hF full-word byteenable constant;
  - RESET_INSTR and the reset PC constant 32'hBFC0_0000, both shared with the PC.
- One sub-module is natural: fetch_watchdog, containing the counter and trip logic, instantiated only under FETCH_WATCHDOG_EN.

Test Plan:
- Zero-wait fetch, pc_address=32'hBFC0_0000, readdata=32'h2402_0005 → read=1 for 1 cycle, fetch=1 for that cycle; instr=32'h2402_0005 next cycle; exec1 then exec2 each 1 cycle; read reasserts on cycle 4.
- waitrequest=1 for 3 cycles in FETCH → read held high 4 cycles with address stable and fetch=0 until cycle 4; instr unchanged until the completing edge.
- mem_stall=1 for 2 cycles on EXEC1 entry → exec1 high 3 cycles, exec2 1 cycle, no read during the stall.
- pc_halt=1 on FETCH entry → read=0; HALTED next cycle; active=0; state stays HALTED for 50 cycles despite toggling inputs.
- Reset pulsed low mid-stall (read=1, waitrequest=1) → read=0, strobes=0, instr=0 asynchronously; fresh fetch after release.
- With FETCH_WATCHDOG_EN and WDOG_LIMIT=4, waitrequest held 1 → bus_error=1 and HALTED after the 4-cycle limit; read=0 afterwards; without the macro, read stays high indefinitely.
